// File: rtl/dualmem_port_arbiter.sv
// rtl/dualmem_port_arbiter.sv - round-robin sharing of one RAM port between two masters
// Optional zero-fill of the whole RAM after reset; 1-cycle read return to the granted master.
module dualmem_port_arbiter #(
    parameter int ADDR_WIDTH    = 13,
    parameter int DATA_WIDTH    = 64,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rstn,

    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_be,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_be,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    output logic [DATA_WIDTH/8-1:0] mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic                    init_done
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    rr_q, rr_d;        // 1 favours m1 when both request
    logic                    done_q;
    logic                    pend_q, pend_d;
    logic                    owner_q, owner_d;  // 1 = read in flight belongs to m1
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata1_q;

    logic                    gnt0, gnt1;
    logic                    sel_we;
    logic [DATA_WIDTH/8-1:0] sel_be;
    logic [DATA_WIDTH/8-1:0] en, we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        pend_d  = 1'b0;
        owner_d = owner_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        sel_we  = 1'b0;
        sel_be  = '0;
        en      = '0;
        we      = '0;
        addr    = addr_q;
        wdata   = wdata_q;
        // Strobes are qualified with rstn so they drop the moment reset asserts.
        if (rstn) begin
            if (state_q == ST_INIT) begin
                en    = '1;
                we    = '1;
                addr  = cnt_q;
                wdata = '0;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end else begin
                gnt0 = m0_req & (~m1_req | ~rr_q);
                gnt1 = m1_req & ~gnt0;
                if (gnt0 | gnt1) begin
                    rr_d   = gnt0;
                    addr   = gnt1 ? m1_addr : m0_addr;
                    sel_we = gnt1 ? m1_we : m0_we;
                    sel_be = gnt1 ? m1_be : m0_be;
                    if (sel_we) begin
                        en    = sel_be;
                        we    = sel_be;
                        wdata = gnt1 ? m1_wdata : m0_wdata;
                    end else begin
                        en      = '1;
                        pend_d  = 1'b1;
                        owner_d = gnt1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            cnt_q    <= '0;
            rr_q     <= 1'b0;
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            done_q  <= done_q | (state_d == ST_RUN);
            pend_q  <= pend_d;
            owner_q <= owner_d;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (m0_rvalid) begin
                rdata0_q <= mem_rdata;
            end
            if (m1_rvalid) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = pend_q & ~owner_q;
    assign m1_rvalid = pend_q & owner_q;
    assign m0_rdata  = m0_rvalid ? mem_rdata : rdata0_q;
    assign m1_rdata  = m1_rvalid ? mem_rdata : rdata1_q;
    assign mem_en    = en;
    assign mem_we    = we;
    assign mem_addr  = addr;
    assign mem_wdata = wdata;
    assign init_done = done_q;

endmodule

// File: tb/tb_dualmem_port_arbiter.sv
// tb/tb_dualmem_port_arbiter.sv - randomized and directed bench for dualmem_port_arbiter
module tb_dualmem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [7:0]  be;
        logic [12:0] addr;
        logic [63:0] wdata;
    } req_t;

    logic        clk;
    logic        rstn;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [7:0]  m0_be;
    logic [12:0] m0_addr;
    logic [63:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [7:0]  m1_be;
    logic [12:0] m1_addr;
    logic [63:0] m1_wdata, m1_rdata;
    logic [7:0]  mem_en, mem_we;
    logic [12:0] mem_addr;
    logic [63:0] mem_wdata, ram_rdata;
    logic        init_done;

    dualmem_port_arbiter u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_be     (m0_be),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_be     (m1_be),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (ram_rdata),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-writable RAM with 1-cycle read latency, preloaded with non-zero junk.
    logic [63:0] ram [0:8191];
    logic        ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 8192; i++) ram[i] <= {$urandom, $urandom} | 64'h1;
            ram_loaded <= 1'b1;
        end else begin
            for (int b = 0; b < 8; b++)
                if (mem_en[b] && mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            if (mem_en != 8'h00 && mem_we == 8'h00) ram_rdata <= ram[mem_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [63:0] exp_mem [0:8191];
    bit          m_init;
    int          m_cnt;
    bit          m_done;
    int          m_fav;
    bit          m_pend;
    int          m_owner;
    logic [63:0] m_pdata;
    logic [63:0] m_hold [2];
    logic [12:0] m_last_addr;
    logic [63:0] m_last_wdata;

    req_t q0[$], q1[$];
    int   gseq[$];
    int   rv0_cnt, rv1_cnt;
    logic [63:0] last_rd0, last_rd1;

    function automatic req_t mk(input logic we, input logic [7:0] be, input logic [12:0] a,
                                input logic [63:0] d);
        req_t r;
        r.we = we; r.be = be; r.addr = a; r.wdata = d;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.we    = 1'($urandom_range(0, 1));
        r.be    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        r.addr  = 13'($urandom_range(0, 31));
        r.wdata = {$urandom, $urandom};
        return r;
    endfunction

    task automatic model_reset();
        m_init = 1'b1; m_cnt = 0; m_done = 1'b0; m_fav = 0;
        m_pend = 1'b0; m_owner = 0; m_pdata = '0;
        m_hold[0] = '0; m_hold[1] = '0;
        m_last_addr = '0; m_last_wdata = '0;
        q0.delete(); q1.delete();
    endtask

    // Entered at posedge+1: drive, sample at posedge+5, advance the model, return at next posedge+1.
    task automatic tick();
        req_t h0, h1, h;
        bit   r0, r1;
        int   g;
        h0 = '0; h1 = '0; h = '0;
        r0 = (q0.size() > 0);
        r1 = (q1.size() > 0);
        if (r0) h0 = q0[0];
        if (r1) h1 = q1[0];
        m0_req = r0; m0_we = h0.we; m0_be = h0.be; m0_addr = h0.addr; m0_wdata = h0.wdata;
        m1_req = r1; m1_we = h1.we; m1_be = h1.be; m1_addr = h1.addr; m1_wdata = h1.wdata;
        #4;
        g = -1;
        if (m_init) begin
            check("init_en", mem_en, 8'hFF);
            check("init_we", mem_we, 8'hFF);
            check("init_addr", mem_addr, 64'(m_cnt));
            check("init_wdata", mem_wdata, 64'h0);
            check("init_gnt0", m0_gnt, 0);
            check("init_gnt1", m1_gnt, 0);
        end else begin
            if (r0 && r1) g = m_fav;
            else if (r0) g = 0;
            else if (r1) g = 1;
            check("gnt0", m0_gnt, g == 0);
            check("gnt1", m1_gnt, g == 1);
            if (g >= 0) begin
                h = (g == 1) ? h1 : h0;
                check("mem_addr", mem_addr, h.addr);
                check("mem_en", mem_en, h.we ? h.be : 8'hFF);
                check("mem_we", mem_we, h.we ? h.be : 8'h00);
                check("mem_wdata", mem_wdata, h.we ? h.wdata : m_last_wdata);
            end else begin
                check("idle_en", mem_en, 8'h00);
                check("idle_we", mem_we, 8'h00);
                check("idle_addr", mem_addr, m_last_addr);
                check("idle_wdata", mem_wdata, m_last_wdata);
            end
        end
        check("init_done", init_done, m_done);
        check("rvalid0", m0_rvalid, m_pend && m_owner == 0);
        check("rvalid1", m1_rvalid, m_pend && m_owner == 1);
        check("rdata0", m0_rdata, (m_pend && m_owner == 0) ? m_pdata : m_hold[0]);
        check("rdata1", m1_rdata, (m_pend && m_owner == 1) ? m_pdata : m_hold[1]);

        gseq.push_back((m0_gnt && m1_gnt) ? 3 : m0_gnt ? 0 : m1_gnt ? 1 : 2);
        if (m0_rvalid) begin rv0_cnt++; last_rd0 = m0_rdata; end
        if (m1_rvalid) begin rv1_cnt++; last_rd1 = m1_rdata; end

        if (m_pend) m_hold[m_owner] = m_pdata;
        m_pend = 1'b0;
        if (m_init) begin
            m_last_addr  = 13'(m_cnt);
            m_last_wdata = '0;
            if (m_cnt == 8191) begin
                m_init = 1'b0;
                m_done = 1'b1;
                for (int i = 0; i < 8192; i++) exp_mem[i] = '0;
            end else begin
                m_cnt++;
            end
        end else if (g >= 0) begin
            m_fav = (g == 0) ? 1 : 0;
            m_last_addr = h.addr;
            if (h.we) begin
                for (int b = 0; b < 8; b++)
                    if (h.be[b]) exp_mem[h.addr][b*8 +: 8] = h.wdata[b*8 +: 8];
                m_last_wdata = h.wdata;
            end else begin
                m_pend  = 1'b1;
                m_owner = g;
                m_pdata = exp_mem[h.addr];
            end
            if (g == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, {m0_gnt, m1_gnt}, 0);
        check({tag, "_rvalid"}, {m0_rvalid, m1_rvalid}, 0);
        check({tag, "_en_we"}, {mem_en, mem_we}, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_rdata0"}, m0_rdata, 0);
        check({tag, "_rdata1"}, m1_rdata, 0);
        check({tag, "_done"}, init_done, 0);
    endtask

    // Pulse reset mid-cycle, check outputs drop immediately, release at next posedge+1.
    task automatic reset_pulse(input string tag);
        #1 rstn = 1'b0;
        #1 check_reset_outputs(tag);
        @(posedge clk);
        #1 rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        rstn = 1'b0;
        m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
        rv0_cnt = 0; rv1_cnt = 0; last_rd0 = '1; last_rd1 = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #5 check_reset_outputs("reset");
        @(posedge clk);
        #1 rstn = 1'b1;

        // Zero-fill with an m0 read parked from counter 100 onward.
        for (int i = 0; i < 8192; i++) begin
            if (i == 100) q0.push_back(mk(1'b0, 8'h00, 13'h1ABC, 64'h0));
            tick();
        end
        gseq.delete(); last_rd0 = '1;
        tick();
        check("first_run_gnt", gseq[0], 0);
        tick();
        check("read_1abc", last_rd0, 64'h0);

        q0.push_back(mk(1'b1, 8'h0F, 13'd5, 64'hDEADBEEF_CAFEF00D));
        q0.push_back(mk(1'b0, 8'h00, 13'd5, 64'h0));
        last_rd0 = '1;
        repeat (3) tick();
        check("be_merge", last_rd0, 64'h00000000_CAFEF00D);

        rv0_cnt = 0; rv1_cnt = 0; gseq.delete();
        for (int a = 1; a <= 3; a++) q1.push_back(mk(1'b0, 8'h00, 13'(a), 64'h0));
        repeat (4) tick();
        check("m1_only_gnts", {gseq[0][1:0], gseq[1][1:0], gseq[2][1:0]}, 6'b01_01_01);
        check("m1_only_rv1", rv1_cnt, 3);
        check("m1_only_rv0", rv0_cnt, 0);

        rv0_cnt = 0; rv1_cnt = 0; gseq.delete();
        for (int k = 0; k < 3; k++) begin
            q0.push_back(mk(1'b0, 8'h00, 13'(10 + k), 64'h0));
            q1.push_back(mk(1'b0, 8'h00, 13'(20 + k), 64'h0));
        end
        repeat (7) tick();
        for (int k = 0; k < 6; k++) check("rr_alternate", gseq[k], k % 2);
        check("rr_rv_counts", {rv0_cnt[7:0], rv1_cnt[7:0]}, {8'd3, 8'd3});

        q1.push_back(mk(1'b1, 8'h00, 13'd7, 64'hFFFF_FFFF_FFFF_FFFF));
        q1.push_back(mk(1'b0, 8'h00, 13'd7, 64'h0));
        last_rd1 = '1;
        repeat (3) tick();
        check("be_zero_write", last_rd1, 64'h0);

        for (int c = 0; c < 3000; c++) begin
            if (q0.size() < 2 && $urandom_range(0, 9) < 6) q0.push_back(rand_req());
            if (q1.size() < 2 && $urandom_range(0, 9) < 6) q1.push_back(rand_req());
            tick();
        end
        while (q0.size() > 0 || q1.size() > 0) tick();
        tick();

        // Reset with an m1 read in flight: the return must be dropped.
        q1.push_back(mk(1'b0, 8'h00, 13'd3, 64'h0));
        tick();
        rv1_cnt = 0;
        reset_pulse("rst_inflight");
        for (int i = 0; i < 4000; i++) tick();
        check("dropped_read", rv1_cnt, 0);
        reset_pulse("rst_midinit");
        for (int i = 0; i < 8192; i++) tick();
        q0.push_back(mk(1'b0, 8'h00, 13'd5, 64'h0));
        last_rd0 = '1;
        repeat (2) tick();
        check("refill_zero", last_rd0, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dualmem_port_arbiter.md
Name: dualmem_port_arbiter

Overview:
- Shares one port of the 8192 x 64-bit byte-writable dual-port RAM between two requesters (m0, m1) using round-robin arbitration.
- After reset, an optional init sequencer zero-fills the whole RAM before any requester is served.
- Sits between two bus-side masters (for example a CPU data port and a debug/DMA loader) and the RAM's A or B port.
- The RAM has 1-cycle synchronous read latency.

Parameters:
- ADDR_WIDTH, 13, word address width (8192 words).
- DATA_WIDTH, 64, data width; byte-enable width is DATA_WIDTH/8.
- INIT_ON_RESET, 1, 1 = zero-fill the RAM after reset; 0 = serve requests immediately.

Ports:
- clk  in  1  single clock for the block and the RAM port.
- rstn  in  1  reset, asynchronous, active-low.
- m0_req  in  1  request; held stable with its fields until m0_gnt.
- m0_we  in  1  1 = write, 0 = read.
- m0_be  in  8  byte enables for writes.
- m0_addr  in  13  word address.
- m0_wdata  in  64  write data.
- m0_gnt  out  1  request accepted this cycle.
- m0_rvalid  out  1  read data valid (cycle after a granted read).
- m0_rdata  out  64  read data.
- m1_*  same set and meanings as m0_*.
- mem_en  out  8  per-byte-lane RAM enable.
- mem_we  out  8  per-byte-lane RAM write enable.
- mem_addr  out  13  RAM address.
- mem_wdata  out  64  RAM write data.
- mem_rdata  in  64  RAM read data; valid 1 cycle after an enabled read.
- init_done  out  1  high once the RAM is usable.

Behaviour:
- Reset (rstn low, asynchronous) forces all of the following:
  - state = INIT if INIT_ON_RESET, else RUN.
  - init counter = 0; RR pointer = m0 priority.
  - m0/m1_gnt = 0, m0/m1_rvalid = 0, init_done = 0.
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, m*_rdata = 0.
- INIT state:
  - Each cycle: mem_en = 8'hFF, mem_we = 8'hFF, mem_addr = counter, mem_wdata = 0.
  - Counter increments 0 -> 8191: exactly 8192 cycles of writes.
  - On the cycle addr 8191 is written, next state = RUN.
  - No grants while in INIT.
- init_done:
  - Registered; rises the first cycle in RUN and stays high until reset.
  - With INIT_ON_RESET = 0, it rises on the first clk edge after rstn deasserts.
- RUN state, arbitration (combinational, same cycle):
  - Exactly one requester granted if any request is present.
  - Both requesting: grant the one the RR pointer favours.
  - RR pointer updates on every grant to favour the non-granted requester.
  - Single requester: granted immediately, no bubble.
  - Throughput: 1 access per cycle.
  - A back-to-back request from the same master while the other is idle is granted every cycle.
- RAM drive in RUN, same cycle as gnt:
  - mem_addr = granted addr.
  - Granted write: mem_en = be, mem_we = be, mem_wdata = wdata.
  - Granted read: mem_en = 8'hFF, mem_we = 0.
  - No grant: mem_en = 0, mem_we = 0; address/data hold the last value.
  - Write with be = 0: granted; RAM not enabled; no data change.
- Read return:
  - A 1-bit owner flag is registered at grant of a read.
  - Next cycle: owner's rvalid = 1 and owner's rdata = mem_rdata.
  - Non-owner rvalid = 0; non-owner rdata holds its previous value.
  - Writes never produce rvalid.
- Simultaneous events:
  - Read returning to m0 while m1 is granted a new read: both happen in the same cycle.
  - Pipeline depth is 1; no stalls.
- Reset mid-INIT restarts the fill from address 0.
- Reset with a read in flight: rvalid is dropped; the read is not replayed.
- Requests arriving during INIT are held off (gnt = 0) and are served in RUN under RR order.

Test Plan:
- INIT_ON_RESET = 1, release reset:
  - mem_we = 8'hFF, addr 0..8191, wdata 0, for exactly 8192 cycles.
  - init_done rises on cycle 8193.
  - A m0 read of addr 0x1ABC then returns 64'h0.
- m0 writes addr 5, be = 8'h0F, wdata = 64'hDEADBEEF_CAFEF00D, then m0 reads addr 5:
  - mem_en/mem_we = 8'h0F on the write.
  - rdata = 64'h00000000_CAFEF00D one cycle after the read grant.
- m0 and m1 both assert read continuously for 6 cycles:
  - Grants alternate m0, m1, m0, m1, m0, m1.
  - Each rvalid goes to the correct master exactly 1 cycle later.
- Only m1 requests, reads of addrs 1, 2, 3 in consecutive cycles:
  - Three consecutive grants.
  - m1_rvalid high for 3 consecutive cycles.
  - m0_rvalid stays 0.
- m0 requests during INIT at counter = 100:
  - m0_gnt stays 0 until the first RUN cycle.
  - Granted in the first RUN cycle.
- rstn pulsed low at INIT counter = 4000, and again while an m1 read is in flight:
  - All outputs go to 0 asynchronously.
  - INIT restarts at addr 0.
  - No m1_rvalid is produced for the dropped read.
